// File: rtl/morse_msg_sequencer.sv
// Message sequencer for the Morse encoder: stores letter codes and plays them one at a time,
// inserting inter-letter gaps, word spaces and optional message repeat.
module morse_msg_sequencer #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int GAP_CYCLES = 1,
  parameter int WORD_GAP   = 3
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          WrEn,
  input  logic [2:0]    WrData,
  input  logic          Clear,
  input  logic          Start,
  input  logic          Abort,
  input  logic          Repeat,
  input  logic          EncIdle,
  output logic [2:0]    EncLetter,
  output logic          Busy,
  output logic          Full,
  output logic          Done,
  output logic [AW:0]   Count,
  output logic [AW-1:0] Index
);

  // state | meaning
  // IDLE  | waiting for Start, buffer writable
  // ISSUE | driving mem[Index] until the encoder leaves its gap state
  // DRAIN | letter accepted, waiting for the encoder to return to its gap state
  // GAP   | extra blank cycles after a letter
  // SPACE | blank cycles for a word space entry
  // NEXT  | advance index, wrap on Repeat or finish
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, GAP, SPACE, NEXT} state_t;

  localparam int CW = 8;
  localparam logic [2:0] SP = 3'd4;

  logic [2:0]    mem [DEPTH];
  state_t        state;
  logic [CW-1:0] cnt;
  logic          wr_ok;
  logic          last;
  logic [AW-1:0] idx_nxt;

  assign Full    = (Count == (AW+1)'(DEPTH));
  assign wr_ok   = WrEn && !Full && !Busy && !Clear;
  assign last    = ({1'b0, Index} == (Count - 1'b1));
  assign idx_nxt = Index + 1'b1;

  // codes 5-7 behave exactly like the space code
  function automatic logic [2:0] code_of(input logic [2:0] c);
    return (c >= SP) ? SP : c;
  endfunction

  always_ff @(posedge Clock) begin
    if (wr_ok) mem[Count[AW-1:0]] <= WrData;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      EncLetter <= SP;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Count     <= '0;
      Index     <= '0;
      cnt       <= '0;
    end else begin
      Done <= 1'b0;
      if (!Busy) begin
        if (Clear)      Count <= '0;
        else if (wr_ok) Count <= Count + 1'b1;
      end
      if (Abort && state != IDLE) begin
        state     <= IDLE;
        Busy      <= 1'b0;
        EncLetter <= SP;
      end else begin
        case (state)
          IDLE: begin
            if (Start && !Abort) begin
              if (Count == '0) begin
                Done <= 1'b1;
              end else begin
                Index     <= '0;
                state     <= ISSUE;
                Busy      <= 1'b1;
                EncLetter <= code_of(mem[0]);
              end
            end
          end
          ISSUE: begin
            // one observed encoder start per letter, then drop back to space
            if (EncLetter == SP) begin
              state <= SPACE;
              cnt   <= CW'(WORD_GAP - 1);
            end else if (!EncIdle) begin
              state     <= DRAIN;
              EncLetter <= SP;
            end
          end
          DRAIN: begin
            if (EncIdle) begin
              if (GAP_CYCLES == 0) begin
                state <= NEXT;
              end else begin
                state <= GAP;
                cnt   <= CW'(GAP_CYCLES - 1);
              end
            end
          end
          GAP, SPACE: begin
            if (cnt == '0) state <= NEXT;
            else           cnt   <= cnt - 1'b1;
          end
          NEXT: begin
            if (last) begin
              if (Repeat) begin
                Index     <= '0;
                state     <= ISSUE;
                EncLetter <= code_of(mem[0]);
              end else begin
                state <= IDLE;
                Busy  <= 1'b0;
                Done  <= 1'b1;
              end
            end else begin
              Index     <= idx_nxt;
              state     <= ISSUE;
              EncLetter <= code_of(mem[idx_nxt]);
            end
          end
          default: begin
            state     <= IDLE;
            Busy      <= 1'b0;
            EncLetter <= SP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Directed bench for morse_msg_sequencer with a small behavioural encoder attached.
module tb_morse_msg_sequencer;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       WrEn = 1'b0, Clear = 1'b0, Start = 1'b0, Abort = 1'b0, Repeat = 1'b0;
  logic [2:0] WrData = 3'd0;
  logic       EncIdle;
  logic [2:0] EncLetter;
  logic       Busy, Full, Done;
  logic [4:0] Count;
  logic [3:0] Index;

  int n_tests = 0;
  int n_fail  = 0;

  morse_msg_sequencer #(.DEPTH(16), .AW(4), .GAP_CYCLES(1), .WORD_GAP(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrData(WrData), .Clear(Clear),
    .Start(Start), .Abort(Abort), .Repeat(Repeat), .EncIdle(EncIdle),
    .EncLetter(EncLetter), .Busy(Busy), .Full(Full), .Done(Done),
    .Count(Count), .Index(Index)
  );

  always #5 Clock = ~Clock;

  // Encoder stand-in: starts whenever idle and a real letter is offered, stays busy a
  // letter-dependent number of cycles; not reset by Resetn, it finishes on its own.
  logic       enc_active = 1'b0;
  int         enc_rem = 0;
  logic [2:0] started [$];

  function automatic int enc_len(input logic [2:0] l);
    case (l)
      3'd0: return 3;
      3'd1: return 1;
      3'd2: return 3;
      default: return 2;
    endcase
  endfunction

  assign EncIdle = !enc_active;

  always @(posedge Clock) begin
    if (!enc_active) begin
      if (EncLetter < 3'd4) begin
        enc_active <= 1'b1;
        enc_rem    <= enc_len(EncLetter);
        started.push_back(EncLetter);
      end
    end else if (enc_rem == 0) begin
      enc_active <= 1'b0;
    end else begin
      enc_rem <= enc_rem - 1;
    end
  end

  task automatic do_write(input logic [2:0] v);
    @(negedge Clock);
    WrData = v; WrEn = 1'b1;
    @(negedge Clock);
    WrEn = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
  endtask

  task automatic do_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Runs until a Done pulse plus a few settle cycles, or until the cycle budget expires.
  task automatic play(input int max_cyc, input int drop_rep_at, output int dones,
                      output bit busy_low, output logic [15:0] seen, output int blanks);
    int post;
    dones = 0; busy_low = 1'b0; seen = '0; blanks = 0; post = 0;
    for (int c = 0; c < max_cyc && post < 5; c++) begin
      @(negedge Clock);
      if (Busy) seen[Index] = 1'b1;
      if (EncIdle && EncLetter == 3'd4 && started.size() == 1) blanks++;
      if (drop_rep_at > 0 && started.size() >= drop_rep_at) Repeat = 1'b0;
      if (Done) begin
        dones++;
        busy_low = !Busy;
      end
      if (dones > 0) post++;
    end
  endtask

  task automatic wait_enc(input logic want_active);
    for (int c = 0; c < 50 && enc_active != want_active; c++) @(negedge Clock);
    n_tests++;
    if (enc_active !== want_active) begin
      n_fail++;
      $display("FAIL wait_enc: active=%0b required=%0b", enc_active, want_active);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    n_tests++;
    if ({EncLetter, Busy, Done, Count, Index} !== {3'd4, 1'b0, 1'b0, 5'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset: let=%0d busy=%0b done=%0b count=%0d idx=%0d required 4/0/0/0/0",
               EncLetter, Busy, Done, Count, Index);
    end
  endtask

  task automatic test_hello();
    logic [2:0] exp [5] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3};
    int d, b; bit bl; logic [15:0] s;
    started.delete();
    for (int i = 0; i < 5; i++) do_write(exp[i]);
    n_tests++;
    if (Count !== 5'd5) begin n_fail++; $display("FAIL hello_count: got %0d required 5", Count); end
    do_start();
    play(400, 0, d, bl, s, b);
    n_tests++;
    if (d != 1 || !bl) begin
      n_fail++; $display("FAIL hello_done: pulses=%0d busy_low=%0b required 1/1", d, bl);
    end
    n_tests++;
    if (started.size() != 5) begin
      n_fail++; $display("FAIL hello_starts: got %0d required 5", started.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (started[i] !== exp[i]) begin
          n_fail++; $display("FAIL hello_letter%0d: got %0d required %0d", i, started[i], exp[i]);
        end
      end
    end
    n_tests++;
    if (EncLetter !== 3'd4 || Count !== 5'd5) begin
      n_fail++; $display("FAIL hello_after: let=%0d count=%0d required 4/5", EncLetter, Count);
    end
  endtask

  task automatic test_space();
    int d, b; bit bl; logic [15:0] s;
    do_clear();
    started.delete();
    do_write(3'd1); do_write(3'd4); do_write(3'd1);
    do_start();
    play(300, 0, d, bl, s, b);
    n_tests++;
    if (started.size() != 2 || started[0] !== 3'd1 || started[1] !== 3'd1) begin
      n_fail++; $display("FAIL space_starts: got %0d starts required 2 E letters", started.size());
    end
    n_tests++;
    if (s !== 16'h0007) begin n_fail++; $display("FAIL space_index: seen=%h required 0007", s); end
    n_tests++;
    if (b < 4) begin n_fail++; $display("FAIL space_gap: blank=%0d required >=4", b); end
    n_tests++;
    if (d != 1) begin n_fail++; $display("FAIL space_done: got %0d required 1", d); end
  endtask

  task automatic test_full();
    int d, b; bit bl; logic [15:0] s;
    do_clear();
    started.delete();
    for (int i = 0; i < 15; i++) do_write(3'd4);
    n_tests++;
    if (Full !== 1'b0) begin n_fail++; $display("FAIL full_early: got %0b required 0", Full); end
    do_write(3'd3);
    n_tests++;
    if (Full !== 1'b1 || Count !== 5'd16) begin
      n_fail++; $display("FAIL full_16: full=%0b count=%0d required 1/16", Full, Count);
    end
    do_write(3'd0);
    n_tests++;
    if (Count !== 5'd16) begin n_fail++; $display("FAIL full_drop: count=%0d required 16", Count); end
    do_start();
    play(600, 0, d, bl, s, b);
    n_tests++;
    if (d != 1 || started.size() != 1 || started[0] !== 3'd3) begin
      n_fail++; $display("FAIL full_last: done=%0d starts=%0d required 1 and single O", d, started.size());
    end
    do_clear();
    n_tests++;
    if (Count !== 5'd0) begin n_fail++; $display("FAIL clear: count=%0d required 0", Count); end
    @(negedge Clock); Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
    n_tests++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      n_fail++; $display("FAIL empty_start: done=%0b busy=%0b required 1/0", Done, Busy);
    end
    @(negedge Clock);
    n_tests++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      n_fail++; $display("FAIL empty_pulse: done=%0b busy=%0b required 0/0", Done, Busy);
    end
  endtask

  task automatic test_repeat();
    int d, b; bit bl; logic [15:0] s;
    do_clear();
    started.delete();
    do_write(3'd3);
    Repeat = 1'b1;
    do_start();
    play(400, 3, d, bl, s, b);
    n_tests++;
    if (started.size() != 3 || d != 1) begin
      n_fail++; $display("FAIL repeat: starts=%0d done=%0d required 3/1", started.size(), d);
    end
  endtask

  task automatic test_abort();
    int d, b; bit bl; logic [15:0] s;
    do_clear();
    started.delete();
    do_write(3'd0); do_write(3'd1);
    do_start();
    wait_enc(1'b1);
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    n_tests++;
    if ({Busy, Done, EncLetter, Count} !== {1'b0, 1'b0, 3'd4, 5'd2}) begin
      n_fail++; $display("FAIL abort: busy=%0b done=%0b let=%0d count=%0d required 0/0/4/2",
                         Busy, Done, EncLetter, Count);
    end
    wait_enc(1'b0);
    started.delete();
    do_start();
    play(300, 0, d, bl, s, b);
    n_tests++;
    if (started.size() != 2 || started[0] !== 3'd0 || d != 1) begin
      n_fail++; $display("FAIL abort_replay: starts=%0d done=%0d required 2 from H/1", started.size(), d);
    end
  endtask

  task automatic test_reset_mid();
    int d, b; bit bl; logic [15:0] s;
    do_start();
    wait_enc(1'b1);
    @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    n_tests++;
    if ({EncLetter, Busy, Count, Index} !== {3'd4, 1'b0, 5'd0, 4'd0}) begin
      n_fail++; $display("FAIL reset_mid: let=%0d busy=%0b count=%0d idx=%0d required 4/0/0/0",
                         EncLetter, Busy, Count, Index);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    wait_enc(1'b0);
    started.delete();
    @(negedge Clock); Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
    n_tests++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_start: done=%0b busy=%0b required 1/0", Done, Busy);
    end
    repeat (5) @(negedge Clock);
    n_tests++;
    if (started.size() != 0) begin
      n_fail++; $display("FAIL reset_nostart: starts=%0d required 0", started.size());
    end
    do_write(3'd3);
    do_start();
    play(200, 0, d, bl, s, b);
    n_tests++;
    if (started.size() != 1 || d != 1) begin
      n_fail++; $display("FAIL reset_reload: starts=%0d done=%0d required 1/1", started.size(), d);
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_space();
    test_full();
    test_repeat();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
